// File: rtl/or1k_spr_access_pkg.sv
// or1k_spr_access_pkg: SPR address field widths, group-0 register map and access FSM states
package or1k_spr_access_pkg;
  localparam int SPR_GROUP_W = 5;
  localparam int SPR_INDEX_W = 11;
  localparam int SPR_ADDR_W = SPR_GROUP_W + SPR_INDEX_W;
  localparam logic [SPR_INDEX_W-1:0] IDX_VR = 11'd0, IDX_UPR = 11'd1, IDX_CPUCFGR = 11'd2,
    IDX_DMMUCFGR = 11'd3, IDX_IMMUCFGR = 11'd4, IDX_DCCFGR = 11'd5, IDX_ICCFGR = 11'd6,
    IDX_DCFGR = 11'd7, IDX_PCCFGR = 11'd8, IDX_VR2 = 11'd9, IDX_AVR = 11'd10;
  typedef enum logic [1:0] {S_IDLE, S_LOCAL, S_BUS, S_RESP} state_e;
  function automatic logic is_local(input logic [SPR_ADDR_W-1:0] addr);
    return addr[SPR_ADDR_W-1:SPR_INDEX_W] == '0 && addr[SPR_INDEX_W-1:0] <= IDX_AVR;
  endfunction
endpackage

// File: rtl/or1k_spr_cfg_mux.sv
// or1k_spr_cfg_mux: selects the static configuration register addressed by a group-0 index
module or1k_spr_cfg_mux
  import or1k_spr_access_pkg::*;
(
  input  logic [SPR_INDEX_W-1:0] idx_i,
  input  logic [31:0]            cfg_vr_i,
  input  logic [31:0]            cfg_vr2_i,
  input  logic [31:0]            cfg_upr_i,
  input  logic [31:0]            cfg_cpucfgr_i,
  input  logic [31:0]            cfg_dmmucfgr_i,
  input  logic [31:0]            cfg_immucfgr_i,
  input  logic [31:0]            cfg_dccfgr_i,
  input  logic [31:0]            cfg_iccfgr_i,
  input  logic [31:0]            cfg_dcfgr_i,
  input  logic [31:0]            cfg_pccfgr_i,
  input  logic [31:0]            cfg_avr_i,
  output logic [31:0]            data_o
);
  always_comb begin
    data_o = '0;
    case (idx_i)
      IDX_VR:       data_o = cfg_vr_i;
      IDX_UPR:      data_o = cfg_upr_i;
      IDX_CPUCFGR:  data_o = cfg_cpucfgr_i;
      IDX_DMMUCFGR: data_o = cfg_dmmucfgr_i;
      IDX_IMMUCFGR: data_o = cfg_immucfgr_i;
      IDX_DCCFGR:   data_o = cfg_dccfgr_i;
      IDX_ICCFGR:   data_o = cfg_iccfgr_i;
      IDX_DCFGR:    data_o = cfg_dcfgr_i;
      IDX_PCCFGR:   data_o = cfg_pccfgr_i;
      IDX_VR2:      data_o = cfg_vr2_i;
      IDX_AVR:      data_o = cfg_avr_i;
      default:      data_o = '0;
    endcase
  end
endmodule

// File: rtl/or1k_spr_access.sv
// or1k_spr_access: serves pipeline SPR accesses from local config registers or an external SPR bus
module or1k_spr_access
  import or1k_spr_access_pkg::*;
#(
  parameter int OPTION_SPR_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spr_req_i,
  input  logic        spr_we_i,
  input  logic [15:0] spr_addr_i,
  input  logic [31:0] spr_wdata_i,
  input  logic        spr_abort_i,
  input  logic [31:0] cfg_vr_i,
  input  logic [31:0] cfg_vr2_i,
  input  logic [31:0] cfg_upr_i,
  input  logic [31:0] cfg_cpucfgr_i,
  input  logic [31:0] cfg_dmmucfgr_i,
  input  logic [31:0] cfg_immucfgr_i,
  input  logic [31:0] cfg_dccfgr_i,
  input  logic [31:0] cfg_iccfgr_i,
  input  logic [31:0] cfg_dcfgr_i,
  input  logic [31:0] cfg_pccfgr_i,
  input  logic [31:0] cfg_avr_i,
  output logic        spr_ack_o,
  output logic [31:0] spr_rdata_o,
  output logic        spr_err_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [15:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d, wdata_q, wdata_d, cfg_data;
  logic [15:0] addr_q, addr_d;
  logic        err_q, err_d, we_q, we_d;

  or1k_spr_cfg_mux u_cfg_mux (
    .idx_i          (spr_addr_i[SPR_INDEX_W-1:0]),
    .cfg_vr_i       (cfg_vr_i),
    .cfg_vr2_i      (cfg_vr2_i),
    .cfg_upr_i      (cfg_upr_i),
    .cfg_cpucfgr_i  (cfg_cpucfgr_i),
    .cfg_dmmucfgr_i (cfg_dmmucfgr_i),
    .cfg_immucfgr_i (cfg_immucfgr_i),
    .cfg_dccfgr_i   (cfg_dccfgr_i),
    .cfg_iccfgr_i   (cfg_iccfgr_i),
    .cfg_dcfgr_i    (cfg_dcfgr_i),
    .cfg_pccfgr_i   (cfg_pccfgr_i),
    .cfg_avr_i      (cfg_avr_i),
    .data_o         (cfg_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_d     = err_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    spr_ack_o = 1'b0;
    case (state_q)
      S_IDLE: if (spr_req_i && !spr_abort_i) begin
        if (is_local(spr_addr_i)) begin
          state_d = S_LOCAL;
          data_d  = spr_we_i ? '0 : cfg_data;
          err_d   = spr_we_i;
        end else begin
          state_d = S_BUS;
          cnt_d   = '0;
          addr_d  = spr_addr_i;
          we_d    = spr_we_i;
          wdata_d = spr_wdata_i;
        end
      end
      S_LOCAL: begin
        state_d   = S_IDLE;
        spr_ack_o = !spr_abort_i;
      end
      S_BUS: if (spr_abort_i) begin
        state_d = S_IDLE;
      end else if (bus_ack_i) begin
        state_d = S_RESP;
        data_d  = we_q ? '0 : bus_rdata_i;
        err_d   = 1'b0;
      end else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == 8'(OPTION_SPR_TIMEOUT)) begin
          state_d = S_RESP;
          data_d  = '0;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d   = S_IDLE;
        spr_ack_o = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign spr_rdata_o = spr_ack_o ? data_q : '0;
  assign spr_err_o   = spr_ack_o & err_q;
  assign bus_stb_o   = state_q == S_BUS;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
endmodule

// File: tb/tb_or1k_spr_access.sv
// tb_or1k_spr_access: randomized and directed checks of SPR access against a transaction-level model
module tb_or1k_spr_access;
  localparam int T = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic spr_req_i = 0, spr_we_i = 0, spr_abort_i = 0, bus_ack_i = 0;
  logic [15:0] spr_addr_i = '0;
  logic [31:0] spr_wdata_i = '0, bus_rdata_i = '0;
  logic [31:0] cfg [11];
  logic spr_ack_o, spr_err_o, bus_stb_o, bus_we_o;
  logic [31:0] spr_rdata_o, bus_wdata_o;
  logic [15:0] bus_addr_o;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  or1k_spr_access #(.OPTION_SPR_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .spr_req_i(spr_req_i), .spr_we_i(spr_we_i), .spr_addr_i(spr_addr_i),
    .spr_wdata_i(spr_wdata_i), .spr_abort_i(spr_abort_i),
    .cfg_vr_i(cfg[0]), .cfg_upr_i(cfg[1]), .cfg_cpucfgr_i(cfg[2]), .cfg_dmmucfgr_i(cfg[3]),
    .cfg_immucfgr_i(cfg[4]), .cfg_dccfgr_i(cfg[5]), .cfg_iccfgr_i(cfg[6]), .cfg_dcfgr_i(cfg[7]),
    .cfg_pccfgr_i(cfg[8]), .cfg_vr2_i(cfg[9]), .cfg_avr_i(cfg[10]),
    .spr_ack_o(spr_ack_o), .spr_rdata_o(spr_rdata_o), .spr_err_o(spr_err_o),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  // Transaction-level expectation: ack cycle counted from acceptance, data, error, strobe cycles.
  function automatic void model(input logic we, input logic [15:0] addr, input logic [31:0] brd,
                                input int ack_after, output int e_ack, output logic [31:0] e_rd,
                                output logic e_er, output int e_stb);
    if (addr[15:11] == 5'd0 && addr[10:0] <= 11'd10) begin
      e_ack = 1; e_rd = we ? 32'd0 : cfg[addr[3:0]]; e_er = we; e_stb = 0;
    end else if (ack_after >= 1 && ack_after <= T) begin
      e_ack = ack_after + 1; e_rd = we ? 32'd0 : brd; e_er = 0; e_stb = ack_after;
    end else begin
      e_ack = T + 1; e_rd = 32'd0; e_er = 1; e_stb = T;
    end
  endfunction

  task automatic run_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                            input int ack_after, input int abort_after, input logic [31:0] brd,
                            output int ack_cyc, output logic [31:0] rd, output logic er,
                            output int stb_cnt, output logic stable);
    int lim;
    ack_cyc = -1; rd = '0; er = 0; stb_cnt = 0; stable = 1;
    lim = abort_after > 0 ? abort_after + 4 : 300;
    @(negedge clk);
    spr_req_i = 1; spr_we_i = we; spr_addr_i = addr; spr_wdata_i = wd;
    for (int c = 1; c <= lim && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (c == abort_after) begin spr_abort_i = 1; spr_req_i = 0; end else spr_abort_i = 0;
      if (bus_stb_o) stb_cnt++;
      bus_ack_i = bus_stb_o && stb_cnt == ack_after;
      bus_rdata_i = bus_ack_i ? brd : $urandom;
      #1;
      if (bus_stb_o && (bus_addr_o !== addr || bus_we_o !== we || bus_wdata_o !== wd)) stable = 0;
      if (spr_ack_o) begin ack_cyc = c; rd = spr_rdata_o; er = spr_err_o; spr_req_i = 0; end
    end
    @(negedge clk);
    spr_req_i = 0; spr_abort_i = 0; bus_ack_i = 0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({spr_ack_o, spr_err_o, bus_stb_o, bus_we_o} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 0000", {spr_ack_o, spr_err_o, bus_stb_o, bus_we_o}); end
    checks++; if ({spr_rdata_o, bus_addr_o, bus_wdata_o} !== 80'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", {spr_rdata_o, bus_addr_o, bus_wdata_o}); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk); #1;
    checks++; if ({spr_ack_o, bus_stb_o} !== 2'b0) begin errors++; $display("FAIL reset_release: got %b exp 00", {spr_ack_o, bus_stb_o}); end
  endtask

  task automatic test_local;
    int a, s; logic [31:0] r; logic e, st;
    run_access(0, 16'h0002, 32'h0, 0, 0, 0, a, r, e, s, st);
    checks++; if (a !== 1) begin errors++; $display("FAIL cpucfgr_ack_cycle: got %0d exp 1", a); end
    checks++; if (r !== 32'h0000_0620 || e !== 1'b0) begin errors++; $display("FAIL cpucfgr_data: got %h/%b exp 00000620/0", r, e); end
    run_access(1, 16'h0000, 32'hFFFF_FFFF, 0, 0, 0, a, r, e, s, st);
    checks++; if (a !== 1 || e !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL vr_write: got ack %0d err %b rd %h exp 1 1 0", a, e, r); end
    checks++; if (s !== 0) begin errors++; $display("FAIL vr_write_stb: got %0d stb cycles exp 0", s); end
    for (int i = 0; i <= 10; i++) begin
      int ea, es; logic [31:0] er_d; logic ee;
      model(0, 16'(i), 0, 0, ea, er_d, ee, es);
      run_access(0, 16'(i), $urandom, 0, 0, 0, a, r, e, s, st);
      checks++; if (a !== ea || r !== er_d || e !== ee || s !== es) begin errors++; $display("FAIL local_idx%0d: got ack %0d rd %h err %b stb %0d exp %0d %h %b %0d", i, a, r, e, s, ea, er_d, ee, es); end
    end
  endtask

  task automatic test_bus;
    int a, s; logic [31:0] r; logic e, st;
    run_access(0, 16'h2801, 0, 3, 0, 32'hDEAD_BEEF, a, r, e, s, st);
    checks++; if (a !== 4 || r !== 32'hDEAD_BEEF || e !== 1'b0) begin errors++; $display("FAIL bus_read: got ack %0d rd %h err %b exp 4 deadbeef 0", a, r, e); end
    checks++; if (s !== 3 || st !== 1'b1) begin errors++; $display("FAIL bus_read_stb: got %0d stable %b exp 3 1", s, st); end
    run_access(1, 16'h4010, 32'hA5A5_0F0F, 0, 0, 0, a, r, e, s, st);
    checks++; if (s !== T || a !== T + 1 || e !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL timeout: got stb %0d ack %0d err %b rd %h exp %0d %0d 1 0", s, a, e, r, T, T + 1); end
    run_access(0, 16'h000B, 0, T, 0, 32'h1357_9BDF, a, r, e, s, st);
    checks++; if (a !== T + 1 || e !== 1'b0 || r !== 32'h1357_9BDF) begin errors++; $display("FAIL terminal_ack: got ack %0d err %b rd %h exp %0d 0 13579bdf", a, e, r, T + 1); end
  endtask

  task automatic test_abort;
    int a, s; logic [31:0] r; logic e, st;
    run_access(0, 16'h2801, 0, 2, 2, 32'hCAFE_0001, a, r, e, s, st);
    checks++; if (a !== -1 || s !== 2) begin errors++; $display("FAIL abort_bus: got ack %0d stb %0d exp -1 2", a, s); end
    run_access(0, 16'h0001, 0, 0, 0, 0, a, r, e, s, st);
    checks++; if (a !== 1 || r !== cfg[1] || e !== 1'b0) begin errors++; $display("FAIL after_abort: got ack %0d rd %h err %b exp 1 %h 0", a, r, e, cfg[1]); end
    run_access(0, 16'h0005, 0, 0, 1, 0, a, r, e, s, st);
    checks++; if (a !== -1) begin errors++; $display("FAIL abort_local: got ack %0d exp -1", a); end
    run_access(0, 16'h3000, 0, 1, 2, 32'h0BAD_F00D, a, r, e, s, st);
    checks++; if (a !== 2 || r !== 32'h0BAD_F00D || e !== 1'b0) begin errors++; $display("FAIL abort_resp: got ack %0d rd %h err %b exp 2 0badf00d 0", a, r, e); end
  endtask

  task automatic test_idle_rules;
    int acks = 0;
    @(negedge clk);
    bus_ack_i = 1; bus_rdata_i = $urandom;
    repeat (3) begin @(negedge clk); #1; acks += int'(spr_ack_o) + int'(bus_stb_o); end
    bus_ack_i = 0; spr_req_i = 1; spr_abort_i = 1; spr_addr_i = 16'h0003; spr_we_i = 0;
    @(negedge clk);
    spr_req_i = 0; spr_abort_i = 0;
    repeat (3) begin #1; acks += int'(spr_ack_o) + int'(bus_stb_o); @(negedge clk); end
    checks++; if (acks !== 0) begin errors++; $display("FAIL idle_ignore: got %0d ack/stb cycles exp 0", acks); end
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    @(negedge clk);
    spr_req_i = 1; spr_we_i = 0; spr_addr_i = 16'h000A;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #1;
      if (spr_ack_o !== 1'(c % 2) || (spr_ack_o && spr_rdata_o !== cfg[10])) bad++;
    end
    spr_req_i = 0;
    @(negedge clk); @(negedge clk);
    checks++; if (bad !== 0) begin errors++; $display("FAIL back_to_back: got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    @(negedge clk);
    spr_req_i = 1; spr_we_i = 1; spr_addr_i = 16'h2801; spr_wdata_i = 32'h1234_5678;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus_stb_o !== 1'b1 || bus_we_o !== 1'b1) begin errors++; $display("FAIL pre_reset_stb: got %b%b exp 11", bus_stb_o, bus_we_o); end
    rst_n = 0; spr_req_i = 0;
    #1;
    checks++; if ({spr_ack_o, spr_err_o, bus_stb_o, bus_we_o, spr_rdata_o, bus_addr_o, bus_wdata_o} !== 84'd0) begin errors++; $display("FAIL mid_reset: got %h exp 0", {spr_ack_o, spr_err_o, bus_stb_o, bus_we_o, spr_rdata_o, bus_addr_o, bus_wdata_o}); end
    @(negedge clk); rst_n = 1;
    repeat (20) begin @(negedge clk); #1; bad += int'(spr_ack_o) + int'(bus_stb_o); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL post_reset_ack: got %0d ack/stb cycles exp 0", bad); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic we; logic [15:0] addr; logic [31:0] wd, brd, r, er_d; int aa, a, s, ea, es; logic e, ee, st;
      we = 1'($urandom); wd = $urandom; brd = $urandom; aa = $urandom_range(0, 20);
      case ($urandom_range(0, 2))
        0: addr = 16'($urandom_range(0, 10));
        1: addr = {5'd0, 11'($urandom_range(11, 2047))};
        default: addr = {5'($urandom_range(1, 31)), 11'($urandom)};
      endcase
      model(we, addr, brd, aa, ea, er_d, ee, es);
      run_access(we, addr, wd, aa, 0, brd, a, r, e, s, st);
      checks++; if (a !== ea || r !== er_d || e !== ee || s !== es || st !== 1'b1) begin errors++; $display("FAIL random%0d addr %h we %b: got ack %0d rd %h err %b stb %0d stable %b exp %0d %h %b %0d 1", n, addr, we, a, r, e, s, st, ea, er_d, ee, es); end
    end
  endtask

  initial begin
    for (int i = 0; i < 11; i++) cfg[i] = $urandom;
    cfg[2] = 32'h0000_0620;
    test_reset;
    test_local;
    test_bus;
    test_abort;
    test_idle_rules;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
